// File: rtl/text_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : text_line_buffer
// Purpose  : One-line character buffer (shift-in / append-with-cursor) with
//            registered per-pixel cell lookup for the VGA text path.
// Revision : 1.0 - initial release
// ============================================================================
module text_line_buffer #(
  parameter int NUM_CHARS = 8,
  parameter int X_ORIGIN  = 80,
  parameter int Y_ORIGIN  = 80,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           del,
  input  logic                           clr,
  input  logic                           mode,
  input  logic [6:0]                     char_in,
  input  logic [9:0]                     x,
  input  logic [9:0]                     y,
  output logic [6:0]                     ascii_out,
  output logic                           char_hit,
  output logic                           cursor_hit,
  output logic [$clog2(NUM_CHARS+1)-1:0] count,
  output logic                           full
);

  localparam int CW = $clog2(NUM_CHARS + 1);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0]    c_SPACE      = 7'h20;
  localparam logic [10:0]   c_X_LO       = 11'(X_ORIGIN);
  localparam logic [10:0]   c_X_HI       = 11'(X_ORIGIN + 8 * NUM_CHARS);
  localparam logic [10:0]   c_Y_LO       = 11'(Y_ORIGIN);
  localparam logic [10:0]   c_Y_HI       = 11'(Y_ORIGIN + 16);
  localparam logic [10:0]   c_Y_CUR      = 11'(Y_ORIGIN + 14);
  localparam logic [9:0]    c_X_OFF      = 10'(X_ORIGIN);
  localparam logic [CW-1:0] c_FULL       = CW'(NUM_CHARS);
  localparam logic [CW-1:0] c_ONE        = CW'(1);
  localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] c_BLINK_ONE  = BW'(1);

  logic [6:0]    mem_q [NUM_CHARS];
  logic [6:0]    mem_d [NUM_CHARS];
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] blink_cnt_q;
  logic          blink_q;
  logic [6:0]    ascii_q;
  logic          char_hit_q, cursor_hit_q;

  logic          w_in_line;
  logic [6:0]    w_idx;
  logic [6:0]    w_cell;
  logic          w_cursor;

  // Origins are cell-aligned, so the ROM can use raw x[2:0]/y[3:0] downstream.
  assign w_in_line = ({1'b0, x} >= c_X_LO) && ({1'b0, x} < c_X_HI) &&
                     ({1'b0, y} >= c_Y_LO) && ({1'b0, y} < c_Y_HI);
  assign w_idx     = 7'((x - c_X_OFF) >> 3);

  always_comb begin
    w_cell = c_SPACE;
    for (int i = 0; i < NUM_CHARS; i++) begin
      if (w_idx == 7'(i)) w_cell = mem_q[i];
    end
  end

  // Underline occupies the bottom two pixel rows of the next free cell.
  assign w_cursor = mode && (count_q != c_FULL) && blink_q && w_in_line &&
                    (w_idx == 7'(count_q)) && ({1'b0, y} >= c_Y_CUR);

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (clr) begin
      for (int i = 0; i < NUM_CHARS; i++) mem_d[i] = c_SPACE;
      count_d = '0;
    end else if (del) begin
      if (count_q != '0) begin
        count_d = count_q - c_ONE;
        if (!mode) begin
          for (int i = 0; i < NUM_CHARS - 1; i++) mem_d[i] = mem_q[i+1];
          mem_d[NUM_CHARS-1] = c_SPACE;
        end else begin
          for (int i = 0; i < NUM_CHARS; i++) begin
            if (count_q == CW'(i + 1)) mem_d[i] = c_SPACE;
          end
        end
      end
    end else if (push) begin
      if (!mode) begin
        for (int i = NUM_CHARS - 1; i > 0; i--) mem_d[i] = mem_q[i-1];
        mem_d[0] = char_in;
        if (count_q != c_FULL) count_d = count_q + c_ONE;
      end else if (count_q != c_FULL) begin
        for (int i = 0; i < NUM_CHARS; i++) begin
          if (count_q == CW'(i)) mem_d[i] = char_in;
        end
        count_d = count_q + c_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHARS; i++) mem_q[i] <= c_SPACE;
      count_q      <= '0;
      blink_cnt_q  <= '0;
      blink_q      <= 1'b0;
      ascii_q      <= c_SPACE;
      char_hit_q   <= 1'b0;
      cursor_hit_q <= 1'b0;
    end else begin
      mem_q        <= mem_d;
      count_q      <= count_d;
      if (blink_cnt_q == c_BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_q     <= ~blink_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + c_BLINK_ONE;
      end
      ascii_q      <= w_in_line ? w_cell : c_SPACE;
      char_hit_q   <= w_in_line;
      cursor_hit_q <= w_cursor;
    end
  end

  assign ascii_out  = ascii_q;
  assign char_hit   = char_hit_q;
  assign cursor_hit = cursor_hit_q;
  assign count      = count_q;
  assign full       = (count_q == c_FULL);

endmodule
`default_nettype wire

// File: doc/text_line_buffer.md
# text_line_buffer

Parametrised single-line text buffer for the VGA text path. It stores NUM_CHARS 7-bit ASCII codes entered from switch/button pulses and supports two entry modes: shift-in and typewriter append with a blinking underline cursor. For each pixel (x, y) from vga_sync it returns the ASCII code of the covered cell and hit flags, registered to align with the synchronous ascii_rom. Each instance replaces a bank of fixed-width text generators with one shift register.

## Interface
- NUM_CHARS, default 8: line length in characters; legal range 1..64.
- X_ORIGIN, default 80: left pixel column; multiple of 8; X_ORIGIN + 8*NUM_CHARS <= 640.
- Y_ORIGIN, default 80: top pixel row; multiple of 16; Y_ORIGIN + 16 <= 480.
- BLINK_DIV, default 12500000: clk cycles per cursor blink half-period; >= 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- push  in  1  single-cycle pulse: enter char_in (already debounced and edge-detected upstream).
- del  in  1  single-cycle pulse: remove most recent character.
- clr  in  1  single-cycle pulse: blank the line.
- mode  in  1  0 = shift-in, 1 = append with cursor.
- char_in  in  7  ASCII code to enter.
- x  in  10  current pixel column.
- y  in  10  current pixel row.
- ascii_out  out  7  code for the current pixel's cell; 0x20 outside the line.
- char_hit  out  1  pixel lies inside the line area.
- cursor_hit  out  1  pixel lies on the visible cursor underline.
- count  out  clog2(NUM_CHARS+1)  number of characters entered.
- full  out  1  count == NUM_CHARS.

## Operation
- Storage: mem[0..NUM_CHARS-1], 7 bits each. Reset and clr set every entry to 0x20 and count to 0.
- Command priority within one cycle is clr > del > push. The losing commands are dropped, not queued.
- Mode 0 push: mem[0] <= char_in; mem[i] <= mem[i-1]; the old mem[N-1] is lost. count increments and saturates at NUM_CHARS.
- Mode 0 del: mem[i] <= mem[i+1]; mem[N-1] <= 0x20. count decrements if count > 0. With count == 0, del is a no-op.
- Mode 1 push: if count < NUM_CHARS, mem[count] <= char_in and count increments. If full, the push is dropped and the buffer is unchanged.
- Mode 1 del: if count > 0, mem[count-1] <= 0x20 and count decrements. Otherwise it is a no-op.
- Mode change: buffer contents and count are preserved. The new mode governs commands from the next cycle on.
- Cell decode:
  - in_line = (X_ORIGIN <= x < X_ORIGIN + 8*NUM_CHARS) and (Y_ORIGIN <= y < Y_ORIGIN + 16).
  - idx = (x - X_ORIGIN) >> 3.
- Pixel-in-cell indexing: the ROM addresses with y[3:0] and x[2:0]. The origin alignment rules keep those bits valid without subtraction.
- Blink: a free-running counter runs 0..BLINK_DIV-1. blink_phase toggles when the counter wraps.
- Cursor: visible only when all of the following hold:
  - mode == 1
  - count < NUM_CHARS
  - blink_phase == 1
  - in_line and idx == count
  - y - Y_ORIGIN is 14 or 15
- Outputs:
  - ascii_out = in_line ? mem[idx] : 0x20.
  - char_hit = in_line.
  - cursor_hit = cursor condition above.

## Timing
- Reset values: ascii_out 0x20, char_hit 0, cursor_hit 0, count 0, full 0, blink counter 0, blink_phase 0.
- Reset is asserted asynchronously and released synchronously by the consumer. A reset mid-command discards that command.
- ascii_out, char_hit and cursor_hit are registered with 1-cycle latency from (x, y). The ROM adds 1 more cycle; the consumer delays x[2:0] by 2 cycles accordingly.
- Commands take effect at the clock edge where the pulse is high. count and full update at the same edge. The new contents are visible on ascii_out for (x, y) sampled at the following edge.
- push held high for k cycles counts as k pushes. No internal edge detection is performed.
- The blink period is 2*BLINK_DIV cycles. blink_phase first goes high BLINK_DIV cycles after reset.

## Test plan
Unless stated otherwise, the bench uses NUM_CHARS=4, X_ORIGIN=80, Y_ORIGIN=80, BLINK_DIV=4.

- Reset, then sweep x 76..116 at y=85 -> ascii_out is 0x20 everywhere; char_hit is high exactly for x 80..111, one cycle late; count=0, full=0.
- Mode 0, push 'A','B','C','D','E' (0x41..0x45) -> mem = E,D,C,B; count=4; full=1. At x=80, y=80, ascii_out=0x45 after 1 cycle. Then one del -> mem = D,C,B,space; count=3.
- Mode 1, push 'H','I' -> mem = H,I,space,space; count=2. At x=96, y=94, cursor_hit toggles every 4 cycles; at y=93 it stays 0.
- Mode 1, push 5 characters -> the fifth is dropped; count=4, full=1, cursor_hit never asserts. Then del -> mem[3]=0x20, count=3.
- Same-cycle pulses:
  - push+del with count=2 -> del wins; count=1.
  - clr+push -> all entries 0x20; count=0.
  - del at count=0 -> no change.
- Assert reset mid-line after 3 pushes, on the edge of a push -> all entries 0x20, count=0, and all outputs at their reset values immediately.
